// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with FWFT read port and sticky overflow/break flags.
// Optional `UART_RX_FIFO_LEVEL_EN adds a fill-level output port.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int DROP_BREAK   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rx_valid,
  input  logic                    uart_rx_break,
  input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    full,
  output logic                    overflow,
  output logic                    break_seen,
  input  logic                    flag_clr
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d, break_seen_q, break_seen_d;
  logic        empty, push, pop, wr_en;

  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push         = uart_rx_valid && !((DROP_BREAK != 0) && uart_rx_break);
    pop          = !empty && rd_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    wr_en        = push && (!full || pop);
    wr_ptr_d     = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d   = (push && full && !pop) || (overflow_q && !flag_clr);
    break_seen_d = (uart_rx_valid && uart_rx_break) || (break_seen_q && !flag_clr);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      break_seen_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      break_seen_q <= break_seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= uart_rx_data;
    end
  end

  assign rd_valid   = !empty;
  assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow   = overflow_q;
  assign break_seen = break_seen_q;

`ifdef UART_RX_FIFO_LEVEL_EN
  assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int PB    = 8;
  localparam int DEPTH = 16;
  localparam int DROP  = 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          uart_rx_valid = 1'b0;
  logic          uart_rx_break = 1'b0;
  logic [PB-1:0] uart_rx_data = '0;
  logic          rd_ready = 1'b0;
  logic          flag_clr = 1'b0;
  logic          rd_valid, full, overflow, break_seen;
  logic [PB-1:0] rd_data;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH), .DROP_BREAK(DROP)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_break (uart_rx_break),
    .uart_rx_data  (uart_rx_data),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .full          (full),
    .overflow      (overflow),
    .break_seen    (break_seen),
    .flag_clr      (flag_clr)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .level         (level)
`endif
  );

  always #5 clk = ~clk;

  int      n_tests = 0;
  int      n_fail  = 0;
  bit      chk_en  = 1'b0;
  logic [PB-1:0] mq[$];
  bit      m_ovf = 1'b0;
  bit      m_brk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte queue plus two sticky bits, stepped once per clock edge.
  task automatic model_step(input bit rn, input bit v, input bit b, input logic [PB-1:0] d,
                            input bit r, input bit c);
    bit push, pop, drop;
    if (!rn) begin
      mq.delete();
      m_ovf = 1'b0;
      m_brk = 1'b0;
      return;
    end
    push = v && !(DROP != 0 && b);
    pop  = r && (mq.size() > 0);
    drop = push && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !drop) mq.push_back(d);
    m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_brk = (v && b) ? 1'b1 : (c ? 1'b0 : m_brk);
  endtask

  task automatic cycle(input bit rn, input bit v, input bit b, input logic [PB-1:0] d,
                       input bit r, input bit c);
    resetn = rn; uart_rx_valid = v; uart_rx_break = b; uart_rx_data = d;
    rd_ready = r; flag_clr = c;
    @(posedge clk);
    model_step(rn, v, b, d, r, c);
    #1;
    resetn = 1'b1; uart_rx_valid = 1'b0; uart_rx_break = 1'b0; rd_ready = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic idle();
    cycle(1, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 8'h00, 0, 0);
    cycle(0, 0, 0, 8'h00, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", rd_valid, mq.size() != 0);
      if (mq.size() != 0) check("rd_data", rd_data, mq[0]);
      check("full", full, mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      check("break_seen", break_seen, m_brk);
`ifdef UART_RX_FIFO_LEVEL_EN
      check("level", level, mq.size());
`endif
    end
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_break_seen", break_seen, 0);

    cycle(1, 1, 0, 8'h41, 0, 0);
    cycle(1, 1, 0, 8'h42, 0, 0);
    cycle(1, 1, 0, 8'h43, 0, 0);
    check("abc_valid", rd_valid, 1);
    check("abc_head", rd_data, 8'h41);
    for (int i = 0; i < 3; i++) begin
      check("abc_pop", rd_data, 8'h41 + i);
      cycle(1, 0, 0, 8'h00, 1, 0);
    end
    check("abc_empty", rd_valid, 0);

    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 8'(i), 0, 0);
    check("fill_full", full, 1);
    check("fill_no_ovf", overflow, 0);
    cycle(1, 1, 0, 8'hAA, 0, 0);
    check("ovf_full", full, 1);
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check("drain_ovf", rd_data, 8'(i));
      cycle(1, 0, 0, 8'h00, 1, 0);
    end
    check("drain_ovf_empty", rd_valid, 0);

    cycle(1, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 8'(i), 0, 0);
    cycle(1, 1, 0, 8'h55, 1, 0);
    check("pp_no_ovf", overflow, 0);
    check("pp_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      check("drain_pp", rd_data, (i < 15) ? 8'(i + 1) : 8'h55);
      cycle(1, 0, 0, 8'h00, 1, 0);
    end
    check("drain_pp_empty", rd_valid, 0);

    cycle(1, 1, 1, 8'h00, 0, 0);
    check("brk_seen", break_seen, 1);
    check("brk_dropped", rd_valid, 0);
    cycle(1, 0, 0, 8'h00, 0, 1);
    check("brk_clr", break_seen, 0);

    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 8'(i), 0, 0);
    cycle(1, 1, 0, 8'hEE, 0, 1);
    check("clr_vs_set", overflow, 1);
    do_reset();
    check("midreset_empty", rd_valid, 0);
    check("midreset_ovf", overflow, 0);

    for (int i = 0; i < 40; i++) cycle(1, 1, 0, 8'($urandom), i % 2, 0);
    for (int i = 0; i < 25; i++) cycle(1, 0, 0, 8'h00, 1, 0);
    check("wrap_drained", rd_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0), 8'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
